// File: rtl/vga_pkg.sv
// Shared constants and encodings for the VGA framebuffer arbiter.
package vga_pkg;

  localparam int ADDR_W       = 17;
  localparam int PIX_W        = 3;
  localparam int PIX_PER_WORD = 4;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;
  localparam int LANE_W       = 2;

  // Draw read-modify-write sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_DATA = 3'd3,
    ST_WR   = 3'd4
  } arbState_t;

  // Owner of a read travelling through the SRAM pipeline.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_RMW  = 2'd2
  } rdTag_t;

endpackage

// File: rtl/vga_pixel_merge.sv
// Replaces one pixel lane of a packed framebuffer word with a new colour.
module vga_pixel_merge
  import vga_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  input  logic [PIX_W-1:0]  color,
  output logic [WORD_W-1:0] merged
);

  // Copy the word and overwrite only the selected lane.
  always_comb begin
    merged = word;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (lane == i[LANE_W-1:0]) begin
        merged[i*PIX_W +: PIX_W] = color;
      end
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port framebuffer SRAM arbiter: fixed-latency video reads with
// absolute priority, and single-pixel draw writes done as read-modify-write.
//
// Draw handshake: a draw request transfers in a cycle where drw_valid and
// drw_ready are both high; drw_valid must stay asserted with stable
// drw_addr/drw_color until that cycle. drw_ready is high only in IDLE.
//
// Bus timing: a decision made in cycle N is registered onto mem_* in N+1,
// and read data returns on mem_rdata in N+2. dbgState mirrors the sequencer.
module vga_mem_arbiter
  import vga_pkg::*;
(
  input  logic              clkDiv,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [WORD_W-1:0] vid_data,
  input  logic              drw_valid,
  output logic              drw_ready,
  input  logic [ADDR_W+1:0] drw_addr,
  input  logic [PIX_W-1:0]  drw_color,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [2:0]        dbgState
);

  arbState_t         state;
  arbState_t         stateNext;

  rdTag_t            busTag;
  rdTag_t            rdTag;

  logic [ADDR_W-1:0] wordQ;
  logic [LANE_W-1:0] laneQ;
  logic [PIX_W-1:0]  colorQ;
  logic [WORD_W-1:0] mergedQ;
  logic [WORD_W-1:0] mergedWord;

  logic              handshake;
  logic              latchReq;
  logic              latchMerged;
  logic              issueEn;
  logic              issueWe;
  logic [ADDR_W-1:0] issueAddr;
  logic [WORD_W-1:0] issueWdata;
  rdTag_t            issueTag;

  assign drw_ready = (state == ST_IDLE);
  assign handshake = drw_valid && drw_ready;
  assign vid_valid = (rdTag == TAG_VID);
  assign vid_data  = mem_rdata;
  assign dbgState  = state;

  // The returning read word with the latched lane replaced by the colour.
  vga_pixel_merge u_merge (
    .word   (mem_rdata),
    .lane   (laneQ),
    .color  (colorQ),
    .merged (mergedWord)
  );

  // Sequencer state register.
  always_ff @(posedge clkDiv or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Bus slot decision: video first, draw sequencer uses any free slot.
  always_comb begin
    stateNext   = state;
    latchReq    = 1'b0;
    latchMerged = 1'b0;
    issueEn     = 1'b0;
    issueWe     = 1'b0;
    issueAddr   = mem_addr;
    issueWdata  = mem_wdata;
    issueTag    = TAG_NONE;

    if (vid_req) begin
      issueEn   = 1'b1;
      issueAddr = vid_addr;
      issueTag  = TAG_VID;
    end

    case (state)
      ST_IDLE: begin
        if (handshake) begin
          latchReq = 1'b1;
          if (vid_req) begin
            stateNext = ST_RD;
          end else begin
            issueEn   = 1'b1;
            issueAddr = drw_addr[ADDR_W+1:2];
            issueTag  = TAG_RMW;
            stateNext = ST_WAIT;
          end
        end
      end
      ST_RD: begin
        if (!vid_req) begin
          issueEn   = 1'b1;
          issueAddr = wordQ;
          issueTag  = TAG_RMW;
          stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stateNext = ST_DATA;
      end
      ST_DATA: begin
        latchMerged = 1'b1;
        if (!vid_req) begin
          issueEn    = 1'b1;
          issueWe    = 1'b1;
          issueAddr  = wordQ;
          issueWdata = mergedWord;
          stateNext  = ST_IDLE;
        end else begin
          stateNext  = ST_WR;
        end
      end
      ST_WR: begin
        if (!vid_req) begin
          issueEn    = 1'b1;
          issueWe    = 1'b1;
          issueAddr  = wordQ;
          issueWdata = mergedQ;
          stateNext  = ST_IDLE;
        end
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Latch the accepted draw request and, later, the merged word.
  always_ff @(posedge clkDiv or negedge rst) begin
    if (!rst) begin
      wordQ   <= '0;
      laneQ   <= '0;
      colorQ  <= '0;
      mergedQ <= '0;
    end else begin
      if (latchReq) begin
        wordQ  <= drw_addr[ADDR_W+1:2];
        laneQ  <= drw_addr[1:0];
        colorQ <= drw_color;
      end
      if (latchMerged) begin
        mergedQ <= mergedWord;
      end
    end
  end

  // Registered SRAM command; address and data hold while the bus is idle.
  always_ff @(posedge clkDiv or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= issueEn;
      mem_we <= issueWe;
      if (issueEn) begin
        mem_addr  <= issueAddr;
        mem_wdata <= issueWdata;
      end
    end
  end

  // Read-tag pipe: owner of the command on the bus, then of the returning data.
  always_ff @(posedge clkDiv or negedge rst) begin
    if (!rst) begin
      busTag <= TAG_NONE;
      rdTag  <= TAG_NONE;
    end else begin
      busTag <= issueTag;
      rdTag  <= (busTag == TAG_VID && mem_we) ? TAG_NONE : busTag;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter with a behavioural SRAM and a
// word-level reference image of the framebuffer.
module tb_vga_mem_arbiter;

  logic        clkDiv = 1'b0;
  logic        rst = 1'b0;
  logic        vid_req = 1'b0;
  logic [16:0] vid_addr = '0;
  logic        vid_valid;
  logic [11:0] vid_data;
  logic        drw_valid = 1'b0;
  logic        drw_ready;
  logic [18:0] drw_addr = '0;
  logic [2:0]  drw_color = '0;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [2:0]  dbgState;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] sram [0:131071];
  logic [11:0] rdata_q = '0;
  logic [11:0] ref_mem [0:511];
  logic [11:0] exp_q [$];

  // Clock and behavioural single-port synchronous SRAM.
  always #5 clkDiv = ~clkDiv;

  always @(posedge clkDiv) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        rdata_q <= sram[mem_addr];
    end
  end
  assign mem_rdata = rdata_q;

  vga_mem_arbiter dut (
    .clkDiv    (clkDiv),
    .rst       (rst),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_valid (vid_valid),
    .vid_data  (vid_data),
    .drw_valid (drw_valid),
    .drw_ready (drw_ready),
    .drw_addr  (drw_addr),
    .drw_color (drw_color),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbgState  (dbgState)
  );

  task automatic tick();
    @(posedge clkDiv);
    #1;
  endtask

  function automatic logic [11:0] ins_pix(input logic [11:0] w, input int lane, input logic [2:0] c);
    logic [11:0] mask;
    mask = 12'h7 << (3 * lane);
    return (w & ~mask) | (12'(c) << (3 * lane));
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vid_req   = 1'($urandom_range(0, 1));
      vid_addr  = 17'($urandom);
      drw_valid = 1'($urandom_range(0, 1));
      drw_addr  = 19'($urandom);
      drw_color = 3'($urandom);
      tick();
      n_cmp++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, vid_valid} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d got en=%b we=%b addr=%h wdata=%h vv=%b want all 0",
                 i, mem_en, mem_we, mem_addr, mem_wdata, vid_valid);
      end
    end
    vid_req = 1'b0; drw_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (drw_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got %b want 1", drw_ready);
    end
    tick();
    n_cmp++;
    if (mem_en !== 1'b0 || vid_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_quiet got en=%b vv=%b want 0 0", mem_en, vid_valid);
    end
  endtask

  task automatic test_video_read();
    sram[17'h10] = 12'hABC;
    vid_req = 1'b1; vid_addr = 17'h10;
    tick();
    vid_req = 1'b0;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h10) begin
      n_err++; $display("FAIL vid_cmd got en=%b we=%b addr=%h want 1 0 00010", mem_en, mem_we, mem_addr);
    end
    n_cmp++;
    if (vid_valid !== 1'b0) begin
      n_err++; $display("FAIL vid_early got %b want 0", vid_valid);
    end
    tick();
    n_cmp++;
    if (vid_valid !== 1'b1 || vid_data !== 12'hABC) begin
      n_err++; $display("FAIL vid_data got vv=%b data=%h want 1 abc", vid_valid, vid_data);
    end
    tick();
    n_cmp++;
    if (vid_valid !== 1'b0) begin
      n_err++; $display("FAIL vid_once got %b want 0", vid_valid);
    end
  endtask

  task automatic test_single_draw();
    sram[5] = 12'h000;
    tick();
    drw_valid = 1'b1; drw_addr = {17'd5, 2'd2}; drw_color = 3'b101;
    n_cmp++;
    if (drw_ready !== 1'b1) begin
      n_err++; $display("FAIL draw_ready_c0 got %b want 1", drw_ready);
    end
    tick();
    drw_valid = 1'b0;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd5 || drw_ready !== 1'b0) begin
      n_err++; $display("FAIL draw_rd_c1 got en=%b we=%b addr=%h rdy=%b want 1 0 00005 0", mem_en, mem_we, mem_addr, drw_ready);
    end
    tick();
    n_cmp++;
    if (mem_en !== 1'b0 || drw_ready !== 1'b0) begin
      n_err++; $display("FAIL draw_c2 got en=%b rdy=%b want 0 0", mem_en, drw_ready);
    end
    tick();
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'd5 || mem_wdata !== 12'h140 || drw_ready !== 1'b1) begin
      n_err++; $display("FAIL draw_wr_c3 got en=%b we=%b addr=%h wdata=%h rdy=%b want 1 1 00005 140 1",
                        mem_en, mem_we, mem_addr, mem_wdata, drw_ready);
    end
    tick();
    n_cmp++;
    if (sram[5] !== 12'h140) begin
      n_err++; $display("FAIL draw_sram got %h want 140", sram[5]);
    end
  endtask

  task automatic test_preempt();
    sram[5] = 12'h000;
    sram[17'h20] = 12'h5A5;
    tick();
    drw_valid = 1'b1; drw_addr = {17'd5, 2'd2}; drw_color = 3'b101;
    tick();
    drw_valid = 1'b0;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd5) begin
      n_err++; $display("FAIL pre_rd_c1 got en=%b we=%b addr=%h want 1 0 00005", mem_en, mem_we, mem_addr);
    end
    tick();
    vid_req = 1'b1; vid_addr = 17'h20;
    tick();
    vid_req = 1'b0;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h20 || drw_ready !== 1'b0) begin
      n_err++; $display("FAIL pre_vid_c3 got en=%b we=%b addr=%h rdy=%b want 1 0 00020 0", mem_en, mem_we, mem_addr, drw_ready);
    end
    tick();
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'd5 || mem_wdata !== 12'h140) begin
      n_err++; $display("FAIL pre_wr_c4 got en=%b we=%b addr=%h wdata=%h want 1 1 00005 140", mem_en, mem_we, mem_addr, mem_wdata);
    end
    n_cmp++;
    if (vid_valid !== 1'b1 || vid_data !== 12'h5A5) begin
      n_err++; $display("FAIL pre_vid_data got vv=%b data=%h want 1 5a5", vid_valid, vid_data);
    end
    tick();
    n_cmp++;
    if (drw_ready !== 1'b1 || sram[5] !== 12'h140) begin
      n_err++; $display("FAIL pre_done_c5 got rdy=%b sram=%h want 1 140", drw_ready, sram[5]);
    end
  endtask

  task automatic test_simultaneous();
    sram[6] = 12'hFFF;
    tick();
    vid_req = 1'b1; vid_addr = 17'h10;
    drw_valid = 1'b1; drw_addr = {17'd6, 2'd1}; drw_color = 3'b011;
    tick();
    vid_req = 1'b0; drw_valid = 1'b0;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h10) begin
      n_err++; $display("FAIL sim_vid_c1 got en=%b we=%b addr=%h want 1 0 00010", mem_en, mem_we, mem_addr);
    end
    tick();
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd6) begin
      n_err++; $display("FAIL sim_rmw_rd_c2 got en=%b we=%b addr=%h want 1 0 00006", mem_en, mem_we, mem_addr);
    end
    n_cmp++;
    if (vid_valid !== 1'b1 || vid_data !== 12'hABC) begin
      n_err++; $display("FAIL sim_vid_data got vv=%b data=%h want 1 abc", vid_valid, vid_data);
    end
    tick();
    n_cmp++;
    if (vid_valid !== 1'b0) begin
      n_err++; $display("FAIL sim_rmw_not_vid got vv=%b want 0", vid_valid);
    end
    tick();
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'd6 || mem_wdata !== 12'hFDF) begin
      n_err++; $display("FAIL sim_wr_c4 got en=%b we=%b addr=%h wdata=%h want 1 1 00006 fdf", mem_en, mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int we_seen;
    sram[7] = 12'h123;
    tick();
    drw_valid = 1'b1; drw_addr = {17'd7, 2'd3}; drw_color = 3'b111;
    tick();
    drw_valid = 1'b0;
    tick();
    n_cmp++;
    if (dbgState !== 3'd3) begin
      n_err++; $display("FAIL rst_mid_in_data got state=%0d want 3", dbgState);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_en, mem_we, vid_valid} !== 3'b000 || dbgState !== 3'd0) begin
      n_err++; $display("FAIL rst_mid_async got en=%b we=%b vv=%b state=%0d want 0 0 0 0", mem_en, mem_we, vid_valid, dbgState);
    end
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) rst = 1'b1;
      tick();
      if (mem_we === 1'b1) we_seen++;
    end
    n_cmp++;
    if (we_seen !== 0 || dbgState !== 3'd0 || sram[7] !== 12'h123) begin
      n_err++; $display("FAIL rst_mid_nowrite got we_pulses=%0d state=%0d sram=%h want 0 0 123", we_seen, dbgState, sram[7]);
    end
  endtask

  task automatic test_random_traffic();
    bit          vid_prev = 0;
    bit [1:0]    vid_pipe = 2'b00;
    bit          pending = 0;
    bit          in_flight = 0;
    int          age = 0;
    bit          req;
    logic [11:0] got;
    for (int a = 0; a < 512; a++) begin
      ref_mem[a] = 12'($urandom);
      sram[a] = ref_mem[a];
    end
    exp_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      n_cmp++;
      if (vid_valid !== vid_pipe[1]) begin
        n_err++; $display("FAIL rnd_vid_valid cyc%0d got %b want %b", cyc, vid_valid, vid_pipe[1]);
      end
      if (vid_pipe[1]) begin
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        n_cmp++;
        if (vid_data !== got) begin
          n_err++; $display("FAIL rnd_vid_data cyc%0d got %h want %h", cyc, vid_data, got);
        end
      end
      if (in_flight) begin
        age++;
        if (drw_ready === 1'b1) begin
          n_cmp++;
          if (age < 3 || age > 6) begin
            n_err++; $display("FAIL rnd_rmw_latency cyc%0d got %0d want 3..6", cyc, age);
          end
          in_flight = 0;
        end else if (age > 8) begin
          n_cmp++; n_err++;
          $display("FAIL rnd_rmw_timeout cyc%0d got busy %0d cycles want <=6", cyc, age);
          in_flight = 0;
        end
      end
      req = (cyc < 1400) && !vid_prev && ($urandom_range(0, 99) < 60);
      vid_req = req;
      vid_addr = 17'($urandom_range(0, 63));
      if (req) exp_q.push_back(ref_mem[vid_addr]);
      vid_pipe = {vid_pipe[0], req};
      vid_prev = req;
      if (!pending) begin
        drw_valid = (cyc < 1400) && ($urandom_range(0, 99) < 50);
        drw_addr  = {17'($urandom_range(256, 287)), 2'($urandom_range(0, 3))};
        drw_color = 3'($urandom);
      end
      if (drw_valid && drw_ready) begin
        ref_mem[drw_addr[18:2]] = ins_pix(ref_mem[drw_addr[18:2]], int'(drw_addr[1:0]), drw_color);
        in_flight = 1;
        age = 0;
        pending = 0;
      end else begin
        pending = drw_valid;
      end
    end
    vid_req = 1'b0; drw_valid = 1'b0;
    tick(); tick();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL rnd_vid_leftover got %0d want 0", exp_q.size());
    end
    for (int a = 256; a < 288; a++) begin
      n_cmp++;
      if (sram[a] !== ref_mem[a]) begin
        n_err++; $display("FAIL rnd_image word %0d got %h want %h", a, sram[a], ref_mem[a]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) sram[a] = '0;
    test_reset();
    test_video_read();
    test_single_draw();
    test_preempt();
    test_simultaneous();
    test_reset_mid_rmw();
    test_random_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
